forth_boot_loader: RTL and testbench

Boot sequencer for the `forth` CPU. Holds the core in reset after power-up, receives a framed program image over a byte stream, writes it word by word into instruction memory, verifies a checksum, and then releases the CPU. It sits between the host byte link (UART RX or debug FIFO), the instruction RAM write port, and the CPU `reset` input.

---
 rtl/forth_boot_loader.sv | 254 +++++++++++++++++++++++++
 tb/tb_forth_boot_loader.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/forth_boot_loader.sv
// Boot sequencer for the forth CPU: receives a framed program image, writes it into
// instruction RAM, verifies the checksum and releases the core. Reload option: FORTH_BOOT_RELOAD_EN.
module forth_boot_loader #(
    parameter int          IMEM_DEPTH     = 1024,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [9:0]  imem_addr,
    output logic [15:0] imem_wdata,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        load_error,
    output logic [10:0] words_loaded
);

    localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]     DEPTH_L  = 17'(IMEM_DEPTH);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LEN_LO  = 4'd1,
        S_LEN_HI  = 4'd2,
        S_DATA_LO = 4'd3,
        S_DATA_HI = 4'd4,
        S_WRITE   = 4'd5,
        S_CSUM    = 4'd6,
        S_RUN     = 4'd7,
        S_ERR     = 4'd8
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [7:0]    lo_q, lo_d;
    logic [7:0]    csum_q, csum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          rx_ready_q, rx_ready_d;
    logic          imem_we_q, imem_we_d;
    logic [9:0]    imem_addr_q, imem_addr_d;
    logic [15:0]   imem_wdata_q, imem_wdata_d;
    logic          cpu_reset_q, cpu_reset_d;
    logic          load_done_q, load_done_d;
    logic          load_error_q, load_error_d;
    logic [10:0]   words_loaded_q, words_loaded_d;

    logic          accept_s;
    logic          timing_s;
    logic          tmo_hit_s;
    logic [10:0]   wl_inc_s;
    logic [15:0]   len_new_s;

    // The checksum is a running XOR over every byte after the sync marker.
    function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            len_q          <= 16'd0;
            lo_q           <= 8'd0;
            csum_q         <= 8'd0;
            tmo_q          <= '0;
            rx_ready_q     <= 1'b1;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= 10'd0;
            imem_wdata_q   <= 16'd0;
            cpu_reset_q    <= 1'b1;
            load_done_q    <= 1'b0;
            load_error_q   <= 1'b0;
            words_loaded_q <= 11'd0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            lo_q           <= lo_d;
            csum_q         <= csum_d;
            tmo_q          <= tmo_d;
            rx_ready_q     <= rx_ready_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            cpu_reset_q    <= cpu_reset_d;
            load_done_q    <= load_done_d;
            load_error_q   <= load_error_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        lo_d           = lo_q;
        csum_d         = csum_q;
        tmo_d          = tmo_q;
        imem_we_d      = 1'b0;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        cpu_reset_d    = cpu_reset_q;
        load_done_d    = 1'b0;
        load_error_d   = load_error_q;
        words_loaded_d = words_loaded_q;

        accept_s  = rx_valid && rx_ready_q;
        wl_inc_s  = words_loaded_q + 11'd1;
        len_new_s = {rx_data, len_q[7:0]};
        tmo_hit_s = (tmo_q == TMO_LAST);
        timing_s  = (state_q == S_LEN_LO)  || (state_q == S_LEN_HI) ||
                    (state_q == S_DATA_LO) || (state_q == S_DATA_HI) ||
                    (state_q == S_WRITE)   || (state_q == S_CSUM);

        if (timing_s && !accept_s) begin
            tmo_d = tmo_q + {{(TW-1){1'b0}}, 1'b1};
        end else begin
            tmo_d = '0;
        end

        // An accepted byte always wins over a timeout expiring in the same cycle.
        case (state_q)
            S_IDLE: begin
                if (accept_s && (rx_data == SYNC_BYTE)) begin
                    state_d        = S_LEN_LO;
                    load_error_d   = 1'b0;
                    words_loaded_d = 11'd0;
                    csum_d         = 8'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LEN_LO: begin
                if (accept_s) begin
                    len_d[7:0] = rx_data;
                    csum_d     = csum_next(csum_q, rx_data);
                    state_d    = S_LEN_HI;
                end else if (tmo_hit_s) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_HI: begin
                if (accept_s) begin
                    len_d  = len_new_s;
                    csum_d = csum_next(csum_q, rx_data);
                    if ({1'b0, len_new_s} > DEPTH_L) begin
                        state_d = S_ERR;
                    end else if (len_new_s == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA_LO;
                    end
                end else if (tmo_hit_s) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_LEN_HI;
                end
            end
            S_DATA_LO: begin
                if (accept_s) begin
                    lo_d    = rx_data;
                    csum_d  = csum_next(csum_q, rx_data);
                    state_d = S_DATA_HI;
                end else if (tmo_hit_s) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_HI: begin
                if (accept_s) begin
                    csum_d       = csum_next(csum_q, rx_data);
                    imem_we_d    = 1'b1;
                    imem_addr_d  = words_loaded_q[9:0];
                    imem_wdata_d = {rx_data, lo_q};
                    state_d      = S_WRITE;
                end else if (tmo_hit_s) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_DATA_HI;
                end
            end
            S_WRITE: begin
                words_loaded_d = wl_inc_s;
                if (tmo_hit_s) begin
                    state_d = S_ERR;
                end else if ({5'd0, wl_inc_s} < len_q) begin
                    state_d = S_DATA_LO;
                end else begin
                    state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (accept_s) begin
                    if (rx_data == csum_q) begin
                        state_d     = S_RUN;
                        cpu_reset_d = 1'b0;
                        load_done_d = 1'b1;
                    end else begin
                        state_d = S_ERR;
                    end
                end else if (tmo_hit_s) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_CSUM;
                end
            end
            S_RUN: begin
`ifdef FORTH_BOOT_RELOAD_EN
                if (accept_s && (rx_data == SYNC_BYTE)) begin
                    state_d        = S_LEN_LO;
                    cpu_reset_d    = 1'b1;
                    load_error_d   = 1'b0;
                    words_loaded_d = 11'd0;
                    csum_d         = 8'd0;
                end else begin
                    state_d = S_RUN;
                end
`else
                state_d = S_RUN;
`endif
            end
            S_ERR: begin
                load_error_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_d == S_WRITE) || (state_d == S_ERR)) begin
            rx_ready_d = 1'b0;
        end else begin
            rx_ready_d = 1'b1;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign load_done    = load_done_q;
    assign load_error   = load_error_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_forth_boot_loader.sv
// Scoreboard bench for forth_boot_loader: a frame-level reference model queues the
// expected RAM writes and frame outcomes; an independent monitor checks them.
module tb_forth_boot_loader;

    localparam int TMO   = 16;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;
    logic [10:0] words_loaded;

    always #5 clk = ~clk;

    forth_boot_loader #(
        .IMEM_DEPTH     (DEPTH),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    typedef logic [7:0] bq_t[$];
    typedef struct packed { logic [9:0] addr; logic [15:0] data; } wr_t;
    typedef struct packed { logic ok; logic [10:0] words; } out_t;

    wr_t  exp_wr[$];
    out_t exp_out[$];
    int   checks   = 0;
    int   failures = 0;
    logic prev_err = 1'b0;
    logic prev_we  = 1'b0;
    logic prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame bytes in, expected writes and outcome out.
    task automatic expect_frame(input bq_t f);
        int len;
        logic [7:0] x;
        len = int'(f[1]) + 256 * int'(f[2]);
        if (len > DEPTH) begin
            exp_out.push_back(out_t'{ok: 1'b0, words: 11'd0});
            return;
        end
        for (int i = 0; i < len; i++)
            exp_wr.push_back(wr_t'{addr: i[9:0], data: {f[4 + 2*i], f[3 + 2*i]}});
        x = 8'h00;
        for (int k = 1; k < f.size() - 1; k++) x = x ^ f[k];
        exp_out.push_back(out_t'{ok: (f[f.size()-1] == x), words: len[10:0]});
    endtask

    function automatic bq_t make_frame(input int len, input bit bad);
        bq_t f;
        logic [7:0] x;
        logic [7:0] b;
        f.push_back(8'hA5);
        f.push_back(len[7:0]);
        f.push_back(len[15:8]);
        x = len[7:0] ^ len[15:8];
        for (int i = 0; i < 2*len; i++) begin
            b = 8'($urandom);
            f.push_back(b);
            x = x ^ b;
        end
        f.push_back(bad ? (x ^ 8'($urandom_range(1, 255))) : x);
        return f;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a write or an outcome.
    always @(negedge clk) begin
        wr_t  w;
        out_t o;
        if (!reset) begin
            if (prev_we) check("we_one_cycle", {31'd0, imem_we}, 32'd0);
            if (prev_done) check("done_one_cycle", {31'd0, load_done}, 32'd0);
            if (imem_we) begin
                check("wr_rx_ready_low", {31'd0, rx_ready}, 32'd0);
                check("wr_expected", (exp_wr.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (exp_wr.size() > 0) begin
                    w = exp_wr.pop_front();
                    check("wr_addr", {22'd0, imem_addr}, {22'd0, w.addr});
                    check("wr_data", {16'd0, imem_wdata}, {16'd0, w.data});
                end
            end
            if (load_done) begin
                check("done_expected", (exp_out.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (exp_out.size() > 0) begin
                    o = exp_out.pop_front();
                    check("outcome_is_done", {31'd0, o.ok}, 32'd1);
                    check("done_words", {21'd0, words_loaded}, {21'd0, o.words});
                    check("done_cpu_reset", {31'd0, cpu_reset}, 32'd0);
                end
            end
            if (load_error && !prev_err) begin
                check("err_expected", (exp_out.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (exp_out.size() > 0) begin
                    o = exp_out.pop_front();
                    check("outcome_is_err", {31'd0, o.ok}, 32'd0);
                    check("err_cpu_reset", {31'd0, cpu_reset}, 32'd1);
                end
            end
        end
        prev_err  = load_error;
        prev_we   = imem_we;
        prev_done = load_done;
    end

    // Driver: present one byte from a negedge and hold it until accepted.
    task automatic send_byte(input logic [7:0] b);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!acc && n < 50) begin
            acc = rx_ready;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (!acc) check("rx_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input bq_t f, input int gapmax);
        foreach (f[i]) begin
            send_byte(f[i]);
            if (gapmax > 0) idle($urandom_range(0, gapmax));
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_garbage(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h5A;
            send_byte(b);
        end
        rx_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_out.size() > 0 || exp_wr.size() > 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_outcomes", exp_out.size(), 32'd0);
        check("drain_writes", exp_wr.size(), 32'd0);
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cpu_reset"},  {31'd0, cpu_reset}, 32'd1);
        check({tag, "_rx_ready"},   {31'd0, rx_ready}, 32'd1);
        check({tag, "_imem_we"},    {31'd0, imem_we}, 32'd0);
        check({tag, "_imem_addr"},  {22'd0, imem_addr}, 32'd0);
        check({tag, "_imem_wdata"}, {16'd0, imem_wdata}, 32'd0);
        check({tag, "_load_done"},  {31'd0, load_done}, 32'd0);
        check({tag, "_load_error"}, {31'd0, load_error}, 32'd0);
        check({tag, "_words"},      {21'd0, words_loaded}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t good;
        bq_t f;
        int  len;
        bit  bad;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        good = '{8'hA5, 8'h03, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h07, 8'hE0, 8'hE7};

        @(negedge clk);
        @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("idle");

        // Good load, back-to-back bytes so the WRITE cycles apply back-pressure.
        send_garbage(3);
        expect_frame(good);
        f = good;
        f.pop_back();
        send_frame(f, 0);
        check("pre_csum_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        send_byte(8'hE7);
        rx_valid = 1'b0;
        check("release_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check("release_done", {31'd0, load_done}, 32'd1);
        drain();
        check("good_words", {21'd0, words_loaded}, 32'd3);
        check("good_error", {31'd0, load_error}, 32'd0);

        // Sync byte while running.
`ifdef FORTH_BOOT_RELOAD_EN
        expect_frame(good);
`endif
        send_byte(8'hA5);
        rx_valid = 1'b0;
`ifdef FORTH_BOOT_RELOAD_EN
        check("run_sync_cpu_reset", {31'd0, cpu_reset}, 32'd1);
`else
        check("run_sync_cpu_reset", {31'd0, cpu_reset}, 32'd0);
`endif
        f = good;
        f.pop_front();
        send_frame(f, 1);
        drain();
        check("run_after_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check("run_after_words", {21'd0, words_loaded}, 32'd3);
        check("run_rx_ready", {31'd0, rx_ready}, 32'd1);

        // Bad checksum, then oversize, then empty frame.
        do_reset();
        f = good;
        f[9] = 8'hE6;
        expect_frame(f);
        send_frame(f, 0);
        drain();
        check("bad_error", {31'd0, load_error}, 32'd1);
        check("bad_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("bad_words", {21'd0, words_loaded}, 32'd3);
        check("bad_idle_ready", {31'd0, rx_ready}, 32'd1);

        f = '{8'hA5, 8'h01, 8'h04};
        expect_frame(f);
        send_frame(f, 0);
        drain();
        check("oversize_error", {31'd0, load_error}, 32'd1);
        check("oversize_words", {21'd0, words_loaded}, 32'd0);

        f = '{8'hA5, 8'h00, 8'h00, 8'h00};
        expect_frame(f);
        send_frame(f, 0);
        drain();
        check("empty_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check("empty_words", {21'd0, words_loaded}, 32'd0);

        // Inter-byte timeout.
        do_reset();
        send_frame('{8'hA5, 8'h02, 8'h00, 8'h11}, 0);
        idle(10);
        check("tmo_early", {31'd0, load_error}, 32'd0);
        exp_out.push_back(out_t'{ok: 1'b0, words: 11'd0});
        idle(12);
        check("tmo_error", {31'd0, load_error}, 32'd1);
        check("tmo_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        drain();

        // Reset in the middle of a frame, after the word at address 1.
        do_reset();
        exp_wr.push_back(wr_t'{addr: 10'd0, data: 16'h0001});
        exp_wr.push_back(wr_t'{addr: 10'd1, data: 16'h0002});
        send_frame('{8'hA5, 8'h03, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00}, 0);
        @(negedge clk);
        check("mid_words_before", {21'd0, words_loaded}, 32'd2);
        check("mid_writes_seen", exp_wr.size(), 32'd0);
        #2 reset = 1'b1;
        #1 check_reset_values("mid_rst");
        @(negedge clk);
        reset = 1'b0;
        expect_frame(good);
        send_frame(good, 2);
        drain();
        check("mid_reload_words", {21'd0, words_loaded}, 32'd3);

        // Largest legal frame.
        do_reset();
        f = make_frame(DEPTH, 1'b0);
        expect_frame(f);
        send_frame(f, 0);
        drain();
        check("full_words", {21'd0, words_loaded}, DEPTH);
        do_reset();
        f = '{8'hA5, 8'h01, 8'h04};
        expect_frame(f);
        send_frame(f, 0);
        drain();

        // Randomized frames.
        for (int it = 0; it < 14; it++) begin
            do_reset();
            send_garbage($urandom_range(0, 2));
            bad = ($urandom_range(0, 3) == 0);
            len = $urandom_range(0, 7);
            if (it % 5 == 4) begin
                len = DEPTH + 1 + $urandom_range(0, 3000);
                f = '{8'hA5, len[7:0], len[15:8]};
            end else begin
                f = make_frame(len, bad);
            end
            expect_frame(f);
            send_frame(f, 3);
            drain();
            if (len > DEPTH) check("rnd_over_words", {21'd0, words_loaded}, 32'd0);
            else check("rnd_words", {21'd0, words_loaded}, len);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
